// File: rtl/cb_bit_unpacker.sv
// Receive-side bit unpacker for the Cb JPEG bitstream: buffers MSB-first words,
// exposes a left-aligned peek window and consumes 1..PEEK_W bits per cycle.
module cb_bit_unpacker #(
    parameter int IN_W   = 32,
    parameter int BUF_W  = 64,
    parameter int PEEK_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [IN_W-1:0]            in_word_i,
    input  logic                       in_valid_i,
    input  logic                       in_last_i,
    input  logic [$clog2(IN_W)-1:0]    in_count_i,
    output logic                       in_ready_o,
    output logic [PEEK_W-1:0]          peek_o,
    output logic [$clog2(PEEK_W+1)-1:0] peek_avail_o,
    input  logic                       cons_valid_i,
    input  logic [$clog2(PEEK_W+1)-1:0] cons_len_i,
    output logic [15:0]                bit_count_o,
    output logic                       stream_done_o,
    output logic                       err_o
);

    localparam int FILL_W  = $clog2(BUF_W + 1);
    localparam int AVAIL_W = $clog2(PEEK_W + 1);

    logic [BUF_W-1:0]  buf_q,  buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              end_pending_q, end_pending_d;
    logic [15:0]       bit_count_q, bit_count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [FILL_W-1:0] avail_full;
    logic [FILL_W-1:0] shift_len;
    logic [FILL_W-1:0] add_len;
    logic [FILL_W-1:0] fill_after;
    logic [IN_W-1:0]   word_mask;
    logic [BUF_W-1:0]  append;
    logic              accept;
    logic              cons_ok;

    // Ready depends only on registered state so the producer sees a stable handshake.
    assign in_ready_o    = (fill_q <= FILL_W'(IN_W)) && !end_pending_q;
    assign avail_full    = (fill_q >= FILL_W'(PEEK_W)) ? FILL_W'(PEEK_W) : fill_q;
    assign peek_avail_o  = avail_full[AVAIL_W-1:0];
    assign peek_o        = buf_q[BUF_W-1 -: PEEK_W];
    assign bit_count_o   = bit_count_q;
    assign stream_done_o = done_q;
    assign err_o         = err_q;

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        accept        = in_valid_i && in_ready_o;
        cons_ok       = cons_valid_i && (cons_len_i != '0)
                        && (FILL_W'(cons_len_i) <= avail_full);
        shift_len     = cons_ok ? FILL_W'(cons_len_i) : '0;
        add_len       = '0;
        if (accept) begin
            add_len = (in_last_i && (in_count_i != '0)) ? FILL_W'(in_count_i) : FILL_W'(IN_W);
        end
        // Bits past the valid length of a partial word must enter the buffer as 0.
        word_mask     = ~({IN_W{1'b1}} >> add_len);
        fill_after    = fill_q - shift_len;
        append        = {in_word_i & word_mask, {(BUF_W-IN_W){1'b0}}} >> fill_after;
        buf_d         = (buf_q << shift_len) | append;
        fill_d        = fill_after + add_len;
        err_d         = err_q | (cons_valid_i && !cons_ok);
        done_d        = end_pending_q && (fill_d == '0);
        bit_count_d   = bit_count_q + 16'(shift_len);
        end_pending_d = end_pending_q | (accept && in_last_i);
        if (done_d) begin
            bit_count_d   = '0;
            end_pending_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q         <= '0;
            fill_q        <= '0;
            end_pending_q <= 1'b0;
            bit_count_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            fill_q        <= fill_d;
            end_pending_q <= end_pending_d;
            bit_count_q   <= bit_count_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_cb_bit_unpacker.sv
// Self-checking bench for cb_bit_unpacker: directed scenarios plus random traffic
// compared against a bit-queue reference model.
module tb_cb_bit_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_word = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  in_count = '0;
    logic        in_ready;
    logic [15:0] peek;
    logic [4:0]  peek_avail;
    logic        cons_valid = 1'b0;
    logic [4:0]  cons_len = '0;
    logic [15:0] bit_count;
    logic        stream_done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the buffered stream is simply a queue of bits, oldest first.
    bit          mq[$];
    logic [15:0] m_bc;
    bit          m_end, m_done, m_err;

    always #5 clk = ~clk;

    cb_bit_unpacker dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_word_i     (in_word),
        .in_valid_i    (in_valid),
        .in_last_i     (in_last),
        .in_count_i    (in_count),
        .in_ready_o    (in_ready),
        .peek_o        (peek),
        .peek_avail_o  (peek_avail),
        .cons_valid_i  (cons_valid),
        .cons_len_i    (cons_len),
        .bit_count_o   (bit_count),
        .stream_done_o (stream_done),
        .err_o         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_avail();
        return (mq.size() < 16) ? mq.size() : 16;
    endfunction

    function automatic logic [15:0] m_peek();
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[15-i] = (i < mq.size()) ? mq[i] : 1'b0;
        return r;
    endfunction

    function automatic bit m_ready();
        return (mq.size() <= 32) && !m_end;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_bc = '0; m_end = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] w, input logic last,
                              input logic [4:0] cnt, input logic cv, input logic [4:0] len);
        bit acc = v && m_ready();
        int n;
        if (cv) begin
            if (len >= 1 && int'(len) <= m_avail()) begin
                repeat (len) void'(mq.pop_front());
                m_bc = m_bc + 16'(len);
            end else begin
                m_err = 1;
            end
        end
        if (acc) begin
            n = (last && cnt != 0) ? int'(cnt) : 32;
            for (int i = 0; i < n; i++) mq.push_back(w[31-i]);
        end
        m_done = m_end && (mq.size() == 0);
        if (m_done) begin
            m_end = 0;
            m_bc = '0;
        end
        if (acc && last) m_end = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".peek"},        32'(peek),        32'(m_peek()));
        check({tag, ".peek_avail"},  32'(peek_avail),  32'(m_avail()));
        check({tag, ".in_ready"},    32'(in_ready),    32'(m_ready()));
        check({tag, ".bit_count"},   32'(bit_count),   32'(m_bc));
        check({tag, ".stream_done"}, 32'(stream_done), 32'(m_done));
        check({tag, ".err"},         32'(err),         32'(m_err));
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] w, input logic last,
                        input logic [4:0] cnt, input logic cv, input logic [4:0] len);
        in_valid = v; in_word = w; in_last = last; in_count = cnt;
        cons_valid = cv; cons_len = len;
        @(posedge clk);
        model_edge(v, w, last, cnt, cv, len);
        #1;
        in_valid = 0; in_last = 0; cons_valid = 0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int avail;
        logic [4:0] len;
        logic cv;

        // Reset values
        #12;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, no consume
        step("acc_a5", 1, 32'hA5A5_A5A5, 0, 0, 0, 0);
        check("acc_a5.peek_const", 32'(peek), 32'hA5A5);
        check("acc_a5.avail_const", 32'(peek_avail), 32'd16);
        check("acc_a5.ready_const", 32'(in_ready), 32'd1);

        // Fill to 64, then consume 4
        do_reset("rst2");
        step("fill1", 1, 32'hFFFF_0000, 0, 0, 0, 0);
        step("fill2", 1, 32'h1234_5678, 0, 0, 0, 0);
        check("full.ready_const", 32'(in_ready), 32'd0);
        step("cons4", 0, 32'h0, 0, 0, 1, 5'd4);
        check("cons4.peek_const", 32'(peek), 32'hFFF0);
        check("cons4.ready_const", 32'(in_ready), 32'd0);
        check("cons4.bc_const", 32'(bit_count), 32'd4);

        // Fill 40 with consume+offer (refused: ready is registered), then a real simultaneous accept+consume
        do_reset("rst3");
        step("f40_a", 1, 32'hAAAA_AAAA, 0, 0, 0, 0);
        step("f40_b", 1, 32'h5555_5555, 0, 0, 1, 5'd16);
        step("f40_c", 0, 32'h0, 0, 0, 1, 5'd8);
        step("f40_sim", 1, 32'hDEAD_BEEF, 0, 0, 1, 5'd8);
        step("f32_sim", 1, 32'hDEAD_BEEF, 0, 0, 1, 5'd8);
        repeat (3) step("f32_drain", 0, 32'h0, 0, 0, 1, 5'd16);

        // Partial last word into empty buffer, drain -> stream_done
        do_reset("rst4");
        step("last3", 1, 32'hC000_0000, 1, 5'd3, 0, 0);
        check("last3.peek_const", 32'(peek), 32'hC000);
        check("last3.avail_const", 32'(peek_avail), 32'd3);
        step("drain3", 0, 32'h0, 0, 0, 1, 5'd3);
        check("drain3.done_const", 32'(stream_done), 32'd1);
        check("drain3.bc_const", 32'(bit_count), 32'd0);
        step("after_done", 0, 32'h0, 0, 0, 0, 0);
        check("after_done.done_const", 32'(stream_done), 32'd0);
        step("restart", 1, 32'h8000_0001, 0, 0, 0, 0);

        // Illegal consumes
        do_reset("rst5");
        step("last5", 1, 32'hF800_0000, 1, 5'd5, 0, 0);
        step("over6", 0, 32'h0, 0, 0, 1, 5'd6);
        check("over6.err_const", 32'(err), 32'd1);
        step("sticky", 0, 32'h0, 0, 0, 1, 5'd2);
        do_reset("rst5b");
        step("w0", 1, 32'h0F0F_0F0F, 0, 0, 0, 0);
        step("len0", 0, 32'h0, 0, 0, 1, 5'd0);
        check("len0.err_const", 32'(err), 32'd1);
        step("len17", 0, 32'h0, 0, 0, 1, 5'd17);

        // Reset mid-stream with fill=48, end pending
        do_reset("rst6");
        step("m1", 1, 32'h1111_1111, 0, 0, 0, 0);
        step("m2", 1, 32'h2222_2222, 1, 5'd16, 0, 0);
        check("m2.ready_const", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        check("midrst.ready_const", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic: first phase legal consumes only, second phase with illegal ones
        for (int phase = 0; phase < 2; phase++) begin
            do_reset("rst_rand");
            for (int i = 0; i < 1500; i++) begin
                avail = m_avail();
                cv = ($urandom_range(0, 3) != 0);
                if (phase == 1 && $urandom_range(0, 40) == 0) len = 5'($urandom_range(0, 20));
                else if (avail > 0) len = 5'($urandom_range(1, avail));
                else begin len = 5'd1; cv = 0; end
                step("rand", $urandom_range(0, 2) != 0, $urandom(), $urandom_range(0, 30) == 0,
                     5'($urandom_range(0, 31)), cv, len);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
